// File: rtl/mux_readout_pkg.sv
// Shared types and default sizes for the result-mux readout sequencer.
// Sizes match the 32-channel systolic array accumulator bank.
package mux_readout_pkg;

  localparam int DEF_NUM_CH = 32;
  localparam int DEF_DATA_W = 17;
  localparam int DEF_SEL_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    PRESENT,
    DONE
  } state_t;

endpackage

// File: rtl/mux_readout_if.sv
// Valid/ready result stream leaving the readout sequencer.
// master = sequencer side, slave = downstream sink.
interface mux_readout_if
  import mux_readout_pkg::*;
#(
  parameter int DW = DEF_DATA_W,
  parameter int SW = DEF_SEL_W
);

  logic [DW-1:0] out_data;
  logic [SW-1:0] out_ch;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;

  modport master (
    output out_data,
    output out_ch,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_ch,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/mux_readout_next_ch_find.sv
// Find-first-set over mask bits strictly above base,
// or over the whole mask when from0 is set.
module next_ch_find
  import mux_readout_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  base,
  input  logic              from0,
  output logic [SEL_W-1:0]  index,
  output logic              found
);

  // scan downward so the lowest qualifying bit is the last one written
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (from0 || (SEL_W'(i) > base))) begin
        index = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_readout_seq.sv
// Drains enabled accumulator channels through the shared result mux
// onto a valid/ready stream; select only moves to enabled channels.
module mux_readout_seq
  import mux_readout_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic [DATA_W-1:0] mux_y,
  mux_readout_if.master     rd,
  output logic              busy,
  output logic              done
);

  state_t              state;
  logic [NUM_CH-1:0]   mask_q;
  logic [DATA_W-1:0]   data_q;
  logic [SEL_W-1:0]    ch_q;
  logic                valid_q;
  logic                last_q;

  logic [SEL_W-1:0]    first_idx;
  logic                first_found;
  logic [SEL_W-1:0]    nxt_idx;
  logic                nxt_found;

  assign rd.out_data  = data_q;
  assign rd.out_ch    = ch_q;
  assign rd.out_valid = valid_q;
  assign rd.out_last  = last_q;

  next_ch_find #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_first (
    .mask  (ch_mask),
    .base  ('0),
    .from0 (1'b1),
    .index (first_idx),
    .found (first_found)
  );

  next_ch_find #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_next (
    .mask  (mask_q),
    .base  (mux_sel),
    .from0 (1'b0),
    .index (nxt_idx),
    .found (nxt_found)
  );

  // pass sequencing; select is only written when moving to a new channel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mask_q  <= '0;
      mux_sel <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            busy   <= 1'b1;
            mask_q <= ch_mask;
            if (first_found) begin
              mux_sel <= first_idx;
              state   <= SETTLE;
            end else begin
              state <= DONE;
            end
          end
        end
        SETTLE: begin
          data_q  <= mux_y;
          ch_q    <= mux_sel;
          valid_q <= 1'b1;
          last_q  <= !nxt_found;
          state   <= PRESENT;
        end
        PRESENT: begin
          if (valid_q && rd.out_ready) begin
            valid_q <= 1'b0;
            if (last_q) begin
              state <= DONE;
            end else begin
              mux_sel <= nxt_idx;
              state   <= SETTLE;
            end
          end
        end
        DONE: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          last_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
